mac_array: RTL and testbench



---
 rtl/mac_pkg.sv | 26 ++
 rtl/mac_array_if.sv | 28 ++
 rtl/mac_lane.sv | 58 +++++
 rtl/mac_array.sv | 138 +++++++++++++
 tb/tb_mac_array.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared types and elaboration helpers for the mac_array block.
package mac_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // Widest accumulation is N products of 2*w bits; n-1 guard bits cover it for n >= 2.
    function automatic int m_width(input int n, input int w);
        return 2 * w + n - 1;
    endfunction

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mac_array_if.sv
// Beat input / result output bundle between the DMA controller and mac_array.
interface mac_array_if
    import mac_pkg::*;
#(
    parameter int N       = 6,
    parameter int WIDTH   = 16,
    parameter int M_WIDTH = m_width(N, WIDTH)
);

    logic                   in_vld;
    logic                   sof;
    logic [N*WIDTH-1:0]     A;
    logic [WIDTH-1:0]       B;
    logic [N*M_WIDTH-1:0]   C;
    logic [N-1:0]           valid;
    logic                   frame_err;

    modport master (
        output in_vld, sof, A, B,
        input  C, valid, frame_err
    );

    modport slave (
        input  in_vld, sof, A, B,
        output C, valid, frame_err
    );

endinterface

// File: rtl/mac_lane.sv
// One multiply-accumulate lane: registered product, then accumulate into M_WIDTH bits.
// MAC_ARRAY_SIGNED_EN selects two's complement operands with sign extension.
module mac_lane #(
    parameter int WIDTH   = 16,
    parameter int M_WIDTH = 37
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mul_en,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               acc_en,
    input  logic               acc_first,
    output logic [M_WIDTH-1:0] acc
);

    localparam int P_W = 2 * WIDTH;
    localparam int X_W = M_WIDTH - P_W;

    logic [P_W-1:0]     a_ext;
    logic [P_W-1:0]     b_ext;
    logic [P_W-1:0]     prod_next;
    logic [P_W-1:0]     prod_reg;
    logic [M_WIDTH-1:0] prod_x;
    logic [M_WIDTH-1:0] acc_reg;
    logic [M_WIDTH-1:0] acc_next;

`ifdef MAC_ARRAY_SIGNED_EN
    // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
    assign a_ext  = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext  = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_x = {{X_W{prod_reg[P_W-1]}}, prod_reg};
`else
    assign a_ext  = {{WIDTH{1'b0}}, a};
    assign b_ext  = {{WIDTH{1'b0}}, b};
    assign prod_x = {{X_W{1'b0}}, prod_reg};
`endif

    assign prod_next = a_ext * b_ext;
    assign acc_next  = acc_first ? prod_x : (acc_reg + prod_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_reg <= '0;
            acc_reg  <= '0;
        end else begin
            if (mul_en) begin
                prod_reg <= prod_next;
            end
            if (acc_en) begin
                acc_reg <= acc_next;
            end
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/mac_array.sv
// N-lane MAC array: frames of N beats produce one C result with a one-cycle valid.
// Build option: define MAC_ARRAY_SIGNED_EN for signed operands (default unsigned).
module mac_array
    import mac_pkg::*;
#(
    parameter int N       = 6,
    parameter int WIDTH   = 16,
    parameter int M_WIDTH = m_width(N, WIDTH)
) (
    input  logic      clk,
    input  logic      rst_n,
    mac_array_if.slave bus
);

    localparam int               CNT_W    = clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;
    logic               err_reg;
    logic               err_next;

    logic               tag_vld;
    logic               tag_first;
    logic               tag_last;

    logic               s1_vld_reg;
    logic               s1_first_reg;
    logic               s1_last_reg;
    logic               s2_last_reg;

    logic [N*M_WIDTH-1:0] acc_all;
    logic [N*M_WIDTH-1:0] c_reg;
    logic [N-1:0]         valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    // A sof inside a frame restarts it; the first tag makes the lanes drop the partial sum.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        tag_vld    = 1'b0;
        tag_first  = 1'b0;
        tag_last   = 1'b0;
        if (bus.in_vld) begin
            case (state_reg)
                IDLE: begin
                    if (bus.sof) begin
                        state_next = ACC;
                        cnt_next   = CNT_ONE;
                        tag_vld    = 1'b1;
                        tag_first  = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                ACC: begin
                    tag_vld = 1'b1;
                    if (bus.sof) begin
                        err_next  = 1'b1;
                        cnt_next  = CNT_ONE;
                        tag_first = 1'b1;
                    end else if (cnt_reg == CNT_LAST) begin
                        tag_last   = 1'b1;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_reg   <= 1'b0;
            s1_first_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s2_last_reg  <= 1'b0;
            valid_reg    <= '0;
            c_reg        <= '0;
        end else begin
            s1_vld_reg <= tag_vld;
            if (tag_vld) begin
                s1_first_reg <= tag_first;
                s1_last_reg  <= tag_last;
            end
            s2_last_reg <= s1_vld_reg & s1_last_reg;
            valid_reg   <= {N{s2_last_reg}};
            if (s2_last_reg) begin
                c_reg <= acc_all;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            mac_lane #(
                .WIDTH   (WIDTH),
                .M_WIDTH (M_WIDTH)
            ) u_lane (
                .clk       (clk),
                .rst_n     (rst_n),
                .mul_en    (tag_vld),
                .a         (bus.A[gi*WIDTH +: WIDTH]),
                .b         (bus.B),
                .acc_en    (s1_vld_reg),
                .acc_first (s1_first_reg),
                .acc       (acc_all[gi*M_WIDTH +: M_WIDTH])
            );
        end
    endgenerate

    assign bus.C         = c_reg;
    assign bus.valid     = valid_reg;
    assign bus.frame_err = err_reg;

endmodule

// File: tb/tb_mac_array.sv
// Randomized and directed bench for mac_array against a frame-level arithmetic model.
module tb_mac_array;

    localparam int N       = 6;
    localparam int WIDTH   = 16;
    localparam int M_WIDTH = 2 * WIDTH + N - 1;

    typedef struct {
        longint               t;
        logic [N*M_WIDTH-1:0] c;
        logic [N-1:0]         v;
    } res_t;

    logic   clk;
    logic   rst_n;
    longint edge_cnt;
    int     vectors;
    int     miscompares;

    res_t   obs_q[$];
    res_t   exp_q[$];

    // Frame-level model: running sums per lane, beat count, sticky error.
    longint m_acc[N];
    int     m_cnt;
    bit     m_in;
    bit     m_err;

    mac_array_if #(.N(N), .WIDTH(WIDTH), .M_WIDTH(M_WIDTH)) bus ();

    mac_array #(.N(N), .WIDTH(WIDTH), .M_WIDTH(M_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (bus.valid !== '0) obs_q.push_back('{edge_cnt, bus.C, bus.valid});
    end

    function automatic longint lane_prod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef MAC_ARRAY_SIGNED_EN
        return longint'($signed(x)) * longint'($signed(y));
`else
        return longint'(x) * longint'(y);
`endif
    endfunction

    task automatic model_beat(input bit s, input logic [N*WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input longint t);
        logic [N*M_WIDTH-1:0] c;
        longint               v;
        if (s) begin
            if (m_in) m_err = 1'b1;
            m_in  = 1'b1;
            m_cnt = 0;
            for (int i = 0; i < N; i++) m_acc[i] = 0;
        end else if (!m_in) begin
            m_err = 1'b1;
            return;
        end
        for (int i = 0; i < N; i++) m_acc[i] += lane_prod(a[i*WIDTH +: WIDTH], b);
        m_cnt++;
        if (m_cnt == N) begin
            for (int i = 0; i < N; i++) begin
                v = m_acc[i];
                c[i*M_WIDTH +: M_WIDTH] = v[M_WIDTH-1:0];
            end
            exp_q.push_back('{t + 2, c, {N{1'b1}}});
            m_in = 1'b0;
        end
    endtask

    task automatic beat(input bit s, input logic [N*WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        bus.in_vld = 1'b1;
        bus.sof    = s;
        bus.A      = a;
        bus.B      = b;
        model_beat(s, a, b, edge_cnt + 1);
    endtask

    // Bubble cycles carry random junk on the qualified fields.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.in_vld = 1'b0;
            bus.sof    = 1'($urandom);
            bus.A      = rand_a();
            bus.B      = WIDTH'($urandom);
        end
    endtask

    function automatic logic [N*WIDTH-1:0] rand_a();
        logic [N*WIDTH-1:0] a;
        for (int i = 0; i < N; i++) a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        return a;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        bus.in_vld = 1'b0;
        rst_n      = 1'b0;
        m_in  = 1'b0;
        m_err = 1'b0;
        m_cnt = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bus.C !== '0 || bus.valid !== '0 || bus.frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got C=%h valid=%b frame_err=%b, need all zero", bus.C, bus.valid, bus.frame_err);
        end
    endtask

    task automatic test_basic();
        res_t o, e;
        for (int k = 1; k <= N; k++) beat(k == 1, {N{16'h0001}}, WIDTH'(k));
        idle(4);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (o.c !== e.c || o.t !== e.t || o.v !== e.v) begin
                miscompares++;
                $display("FAIL basic_result: got C=%h valid=%b edge %0d, need C=%h valid=%b edge %0d", o.c, o.v, o.t, e.c, e.v, e.t);
            end
        end
        vectors++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL basic_count: %0d unexpected results, %0d missing results", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end
        vectors++;
        if (bus.C !== {N{M_WIDTH'(21)}}) begin
            miscompares++;
            $display("FAIL basic_c21: got C=%h, need every lane 21", bus.C);
        end
    endtask

    task automatic test_range();
        res_t o, e;
        logic [M_WIDTH-1:0] want;
`ifdef MAC_ARRAY_SIGNED_EN
        want = M_WIDTH'(6);
`else
        want = 37'h5FFF40006;
`endif
        for (int k = 0; k < N; k++) beat(k == 0, {N{16'hFFFF}}, 16'hFFFF);
        idle(4);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (o.c !== e.c || o.t !== e.t || o.v !== e.v) begin
                miscompares++;
                $display("FAIL range_result: got C=%h valid=%b edge %0d, need C=%h valid=%b edge %0d", o.c, o.v, o.t, e.c, e.v, e.t);
            end
        end
        vectors++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL range_count: %0d unexpected results, %0d missing results", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end
        vectors++;
        if (bus.C !== {N{want}}) begin
            miscompares++;
            $display("FAIL range_c: got C=%h, need every lane %h", bus.C, want);
        end
    endtask

    task automatic test_signed();
        res_t o, e;
        logic [M_WIDTH-1:0] want;
`ifdef MAC_ARRAY_SIGNED_EN
        want = M_WIDTH'(-12);
`else
        want = M_WIDTH'(786420);
`endif
        for (int k = 0; k < N; k++) beat(k == 0, {N{16'hFFFF}}, 16'h0002);
        idle(4);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (o.c !== e.c || o.t !== e.t || o.v !== e.v) begin
                miscompares++;
                $display("FAIL signed_result: got C=%h valid=%b edge %0d, need C=%h valid=%b edge %0d", o.c, o.v, o.t, e.c, e.v, e.t);
            end
        end
        vectors++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL signed_count: %0d unexpected results, %0d missing results", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end
        vectors++;
        if (bus.C !== {N{want}}) begin
            miscompares++;
            $display("FAIL signed_c: got C=%h, need every lane %h", bus.C, want);
        end
    endtask

    task automatic test_back_to_back();
        res_t o, e;
        for (int k = 1; k <= N; k++) begin
            beat(k == 1, {N{16'h0001}}, WIDTH'(k));
            if (k == 2) idle(3);
        end
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) beat(k == 0, rand_a(), WIDTH'($urandom));
        end
        idle(4);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (o.c !== e.c || o.t !== e.t || o.v !== e.v) begin
                miscompares++;
                $display("FAIL b2b_result: got C=%h valid=%b edge %0d, need C=%h valid=%b edge %0d", o.c, o.v, o.t, e.c, e.v, e.t);
            end
        end
        vectors++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_count: %0d unexpected results, %0d missing results", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end
        vectors++;
        if (bus.frame_err !== m_err) begin
            miscompares++;
            $display("FAIL b2b_frame_err: got %b, need %b", bus.frame_err, m_err);
        end
    endtask

    task automatic test_abort();
        res_t o, e;
        for (int k = 0; k < 3; k++) beat(k == 0, rand_a(), WIDTH'($urandom));
        for (int k = 0; k < N; k++) beat(k == 0, rand_a(), WIDTH'($urandom));
        idle(4);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (o.c !== e.c || o.t !== e.t || o.v !== e.v) begin
                miscompares++;
                $display("FAIL abort_result: got C=%h valid=%b edge %0d, need C=%h valid=%b edge %0d", o.c, o.v, o.t, e.c, e.v, e.t);
            end
        end
        vectors++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL abort_count: %0d unexpected results, %0d missing results", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end
        vectors++;
        if (bus.frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_frame_err: got %b, need 1", bus.frame_err);
        end
    endtask

    task automatic test_random();
        res_t o, e;
        int   kind;
        int   nb;
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                beat(1'b0, rand_a(), WIDTH'($urandom));
            end else begin
                nb = (kind == 1) ? $urandom_range(1, N - 1) : N;
                for (int k = 0; k < nb; k++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    beat(k == 0, rand_a(), WIDTH'($urandom));
                end
            end
        end
        idle(4);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); vectors++;
            if (o.c !== e.c || o.t !== e.t || o.v !== e.v) begin
                miscompares++;
                $display("FAIL random_result: got C=%h valid=%b edge %0d, need C=%h valid=%b edge %0d", o.c, o.v, o.t, e.c, e.v, e.t);
            end
        end
        vectors++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL random_count: %0d unexpected results, %0d missing results", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end
        vectors++;
        if (bus.frame_err !== m_err) begin
            miscompares++;
            $display("FAIL random_frame_err: got %b, need %b", bus.frame_err, m_err);
        end
    endtask

    task automatic test_reset_midframe();
        for (int k = 0; k < N; k++) beat(k == 0, rand_a(), WIDTH'($urandom));
        // Reset lands after the last beat's edge, before its result would appear.
        do_reset();
        idle(4);
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_mid_valid: got %0d valid pulses, need 0", obs_q.size());
            obs_q.delete();
        end
        vectors++;
        if (bus.C !== '0 || bus.frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_state: got C=%h frame_err=%b, need 0 and 0", bus.C, bus.frame_err);
        end
        beat(1'b0, rand_a(), WIDTH'($urandom));
        idle(2);
        vectors++;
        if (bus.frame_err !== 1'b1 || m_err !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_nosof: got frame_err=%b, need 1", bus.frame_err);
        end
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_mid_stray: got %0d valid pulses, need 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.in_vld  = 1'b0;
        bus.sof     = 1'b0;
        bus.A       = '0;
        bus.B       = '0;
        m_in  = 1'b0;
        m_err = 1'b0;
        m_cnt = 0;
        test_reset();
        test_basic();
        test_range();
        test_signed();
        test_back_to_back();
        test_abort();
        test_random();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
